// File: rtl/apb_nslave_master_if.sv
// apb_nslave_master_if: APB bus between the bridge (master) and NUM_SLV slaves
interface apb_nslave_master_if #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2
);
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_nslave_master.sv
// apb_nslave_master: parametrised APB master bridge decoding NUM_SLV slaves from the upper address bits.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_nslave_master #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TMO_CYC = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                transfer,
    input  logic                READ_WRITE,
    input  logic [ADDR_W-1:0]   apb_read_paddr,
    input  logic [ADDR_W-1:0]   apb_write_paddr,
    input  logic [DATA_W-1:0]   apb_write_data,
    output logic                cmd_ready,
    output logic                xfer_done,
    output logic                xfer_err,
    output logic [DATA_W-1:0]   apb_read_data_out,
    apb_nslave_master_if.master apb
);
    localparam int SEL_W = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t            state, state_nx;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] rdata;
    logic              rdy, slv_err, cmd_ok, accept, acc_ok, tmo, fin;

    if (NUM_SLV < 1 || NUM_SLV > 16 || TMO_CYC < 1) begin : g_bad_cfg
        $error("apb_nslave_master: NUM_SLV must be 1..16 and TMO_CYC >= 1");
    end

    assign sel      = apb.paddr[ADDR_W-1 -: SEL_W];
    assign cmd_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    assign cmd_ok   = int'(cmd_addr[ADDR_W-1 -: SEL_W]) < NUM_SLV;

    // Slave mux: an out-of-range sel matches no slave, so its ready/err/data read as 0
    always_comb begin
        rdy      = 1'b0;
        slv_err  = 1'b0;
        rdata    = '0;
        apb.psel = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (sel == SEL_W'(i)) begin
                rdy         = apb.pready[i];
                slv_err     = apb.pslverr[i];
                rdata       = apb.prdata[i*DATA_W +: DATA_W];
                apb.psel[i] = state == SETUP || state == ACCESS;
            end
    end

    assign apb.penable = state == ACCESS;
    assign acc_ok      = state == ACCESS && rdy;
    assign cmd_ready   = !preset && (state == IDLE || acc_ok);
    assign accept      = cmd_ready && transfer;
    assign fin         = acc_ok || tmo || state == DERR;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge pclk or posedge preset)
        if (preset) tmo_cnt <= '0;
        else if (state == SETUP) tmo_cnt <= '0;
        else if (state == ACCESS) tmo_cnt <= tmo_cnt + CNT_W'(1);

    // Fires in the TMO_CYC-th ACCESS cycle still lacking pready
    assign tmo = state == ACCESS && !rdy && tmo_cnt == CNT_W'(TMO_CYC - 1);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset)
        if (preset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (accept) state_nx = cmd_ok ? SETUP : DERR;
        else if (state == SETUP) state_nx = ACCESS;
        else if (state == DERR || acc_ok || tmo) state_nx = IDLE;
    end

    // Decode errors and timeouts complete as failed reads returning zero
    always_ff @(posedge pclk or posedge preset)
        if (preset) begin
            apb.paddr         <= '0;
            apb.pwrite        <= 1'b0;
            apb.pwdata        <= '0;
            xfer_done         <= 1'b0;
            xfer_err          <= 1'b0;
            apb_read_data_out <= '0;
        end else begin
            xfer_done <= fin;
            xfer_err  <= (acc_ok && slv_err) || tmo || state == DERR;
            if (fin && !apb.pwrite) apb_read_data_out <= acc_ok ? rdata : '0;
            if (accept) begin
                apb.paddr  <= cmd_addr;
                apb.pwrite <= !READ_WRITE;
                apb.pwdata <= READ_WRITE ? '0 : apb_write_data;
            end
        end
endmodule
